// File: rtl/sccb_reg_writer.sv
// SCCB 3-phase register writer: DEV_ID, reg_addr, reg_data over SIOC/SIOD.
// Optional ACK/NACK sampling is built only when SCCB_ACK_CHECK_EN is defined.
module sccb_reg_writer #(
  parameter int          CLK_FREQ_HZ  = 50_000_000,
  parameter int          SCCB_FREQ_HZ = 100_000,
  parameter logic [7:0]  DEV_ID       = 8'h42
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       start,
  input  logic [7:0] reg_addr,
  input  logic [7:0] reg_data,
  output logic       ready,
  output logic       done,
  output logic       sioc,
  output logic       siod_oe,
  input  logic       siod_in,
  output logic       nack
);

  localparam int QDIV = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
  localparam int QW   = (QDIV > 2) ? $clog2(QDIV) : 1;
  localparam logic [QW-1:0] QLAST = QW'(QDIV - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] BITS  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  if (QDIV < 2) begin : g_bad_qdiv
    $error("sccb_reg_writer: QDIV must be at least 2");
  end

  logic [1:0]    state, state_n;
  logic [QW-1:0] qcnt, qcnt_n;
  logic [1:0]    q, q_n;
  logic [4:0]    bitc, bitc_n;
  logic [26:0]   sr;
  logic          accept, tick, ph_end, fin;
  logic          bit_n, ack_n;
  logic          sioc_n, oe_n;

  assign accept = start & ready;
  assign tick   = (qcnt == QLAST);
  assign ph_end = tick & (q == 2'd3);
  assign fin    = (state == STOP) & ph_end;

  // Sequencing: quarter counter, quarter index, bit index, state.
  always_comb begin
    state_n = state;
    qcnt_n  = qcnt;
    q_n     = q;
    bitc_n  = bitc;
    if (state == IDLE) begin
      if (start) state_n = START;
    end else begin
      qcnt_n = tick ? '0 : qcnt + QW'(1);
      if (tick) q_n = q + 2'd1;
      if (ph_end) begin
        unique case (state)
          START: begin
            state_n = BITS;
            bitc_n  = 5'd0;
          end
          BITS: begin
            if (bitc == 5'd26) state_n = STOP;
            else bitc_n = bitc + 5'd1;
          end
          default: begin
            state_n = IDLE;
            bitc_n  = 5'd0;
          end
        endcase
      end
    end
  end

  assign bit_n = sr[5'd26 - bitc_n];
  assign ack_n = (bitc_n == 5'd8) | (bitc_n == 5'd17) |
                 (bitc_n == 5'd26);

  // Bus levels for the upcoming cycle, so outputs leave a register.
  always_comb begin
    sioc_n = 1'b1;
    oe_n   = 1'b0;
    unique case (state_n)
      START: begin
        sioc_n = (q_n != 2'd3);
        oe_n   = (q_n != 2'd0);
      end
      BITS: begin
        sioc_n = q_n[1];
        oe_n   = ~ack_n & ~bit_n;
      end
      STOP: begin
        sioc_n = (q_n != 2'd0);
        oe_n   = ~q_n[1];
      end
      default: ;
    endcase
  end

  // State, counters, frame latch and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      qcnt    <= '0;
      q       <= 2'd0;
      bitc    <= 5'd0;
      sr      <= '0;
      ready   <= 1'b1;
      done    <= 1'b0;
      sioc    <= 1'b1;
      siod_oe <= 1'b0;
    end else begin
      state   <= state_n;
      qcnt    <= qcnt_n;
      q       <= q_n;
      bitc    <= bitc_n;
      ready   <= (state_n == IDLE);
      done    <= fin;
      sioc    <= sioc_n;
      siod_oe <= oe_n;
      if (accept)
        sr <= {DEV_ID, 1'b0, reg_addr, 1'b0, reg_data, 1'b0};
    end
  end

`ifdef SCCB_ACK_CHECK_EN
  logic ack_smp;
  assign ack_smp = (state == BITS) & (q == 2'd2) & (qcnt == '0) &
                   ((bitc == 5'd8) | (bitc == 5'd17) |
                    (bitc == 5'd26));

  // Sticky NACK: set by a released ACK slot, cleared on accept.
  always_ff @(posedge Clk) begin
    if (Reset)                   nack <= 1'b0;
    else if (accept)             nack <= 1'b0;
    else if (ack_smp & siod_in)  nack <= 1'b1;
  end
`else
  logic unused_siod;
  assign unused_siod = siod_in;
  assign nack        = 1'b0;
`endif

endmodule

// File: tb/tb_sccb_reg_writer.sv
// Self-checking bench for sccb_reg_writer with a timeline model.
// Runs at a reduced clock (QDIV=4) so many frames fit in the run.
module tb_sccb_reg_writer;

  localparam int CLK_HZ  = 1_600_000;
  localparam int SCCB_HZ = 100_000;
  localparam int Q       = 4;
  localparam int PH      = 4 * Q;
  localparam int TXN     = 29 * PH;
  localparam int LIMIT   = TXN + 50;
  localparam logic [7:0] DEV = 8'h42;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] reg_addr = 8'h00;
  logic [7:0] reg_data = 8'h00;
  logic       siod_in = 1'b0;
  logic       ready, done, sioc, siod_oe, nack;

  sccb_reg_writer #(
    .CLK_FREQ_HZ (CLK_HZ),
    .SCCB_FREQ_HZ(SCCB_HZ),
    .DEV_ID      (DEV)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .start   (start),
    .reg_addr(reg_addr),
    .reg_data(reg_data),
    .ready   (ready),
    .done    (done),
    .sioc    (sioc),
    .siod_oe (siod_oe),
    .siod_in (siod_in),
    .nack    (nack)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: time since accept drives everything.
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic       m_nack = 1'b0;
  int         m_t = 0;
  logic [7:0] m_addr = 8'h00;
  logic [7:0] m_data = 8'h00;

  always @(posedge Clk) begin
    if (Reset) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_nack = 1'b0;
      m_t    = 0;
    end else if (!m_busy && start) begin
      m_busy = 1'b1;
      m_done = 1'b0;
      m_nack = 1'b0;
      m_t    = 0;
      m_addr = reg_addr;
      m_data = reg_data;
    end else if (m_busy) begin
`ifdef SCCB_ACK_CHECK_EN
      if (siod_in && (m_t == 9*PH + 2*Q || m_t == 18*PH + 2*Q ||
                      m_t == 27*PH + 2*Q))
        m_nack = 1'b1;
`endif
      m_t++;
      m_done = (m_t == TXN);
      if (m_done) m_busy = 1'b0;
    end else begin
      m_done = 1'b0;
    end
  end

  function automatic logic [1:0] exp_bus(input int t,
                                         input logic [7:0] a,
                                         input logic [7:0] d);
    int ph, qq, k, pos;
    logic [7:0] b;
    ph = t / PH;
    qq = (t % PH) / Q;
    if (ph == 0) return {qq != 3, qq != 0};
    if (ph <= 27) begin
      k   = ph - 1;
      pos = k % 9;
      b   = (k / 9 == 0) ? DEV : ((k / 9 == 1) ? a : d);
      if (pos == 8) return {qq >= 2, 1'b0};
      return {qq >= 2, ~b[7-pos]};
    end
    return {qq != 0, qq < 2};
  endfunction

  int          ndone = 0;
  int          nrise = 0;
  logic        p_sioc = 1'b1;
  logic        p_oe = 1'b0;
  logic        st_seen = 1'b0;
  logic        sp_seen = 1'b0;
  logic [26:0] dec = '0;

  // Per-cycle compare plus a bus-level frame decoder.
  always @(negedge Clk) begin
    logic [1:0] eb;
    eb = m_busy ? exp_bus(m_t, m_addr, m_data) : 2'b10;
    chk("outs{ready,done,sioc,oe,nack}",
        {27'd0, ready, done, sioc, siod_oe, nack},
        {27'd0, !m_busy, m_done, eb, m_nack});
    if (done) ndone++;
    if (Reset) begin
      nrise   = 0;
      st_seen = 1'b0;
      sp_seen = 1'b0;
    end else begin
      if (p_sioc && sioc && !p_oe && siod_oe) begin
        st_seen = 1'b1;
        sp_seen = 1'b0;
        nrise   = 0;
      end
      if (p_sioc && sioc && p_oe && !siod_oe) sp_seen = 1'b1;
      if (!p_sioc && sioc) begin
        if (nrise < 27) dec = {dec[25:0], ~siod_oe};
        nrise++;
      end
    end
    if (m_done) begin
      chk("bus_dev", {24'd0, dec[26:19]}, {24'd0, DEV});
      chk("bus_addr", {24'd0, dec[17:10]}, {24'd0, m_addr});
      chk("bus_data", {24'd0, dec[8:1]}, {24'd0, m_data});
      chk("bus_ack_released", {29'd0, dec[18], dec[9], dec[0]}, 3'b111);
      chk("bus_sioc_rises", nrise, 28);
      chk("bus_start_stop", {30'd0, st_seen, sp_seen}, 2'b11);
    end
    p_sioc = sioc;
    p_oe   = siod_oe;
  end

  initial forever begin
    @(negedge Clk);
    siod_in = 1'($urandom_range(0, 1));
  end

  task automatic wait_done(input int poke, input logic [7:0] pa,
                           input logic [7:0] pd, output int n);
    n = 0;
    while (n < LIMIT) begin
      @(posedge Clk);
      n++;
      @(negedge Clk);
      if (n == poke) begin
        start    = 1'b1;
        reg_addr = pa;
        reg_data = pd;
      end
      if (n == poke + 1) start = 1'b0;
      if (done) break;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d,
                          input int poke, input logic [7:0] pa,
                          input logic [7:0] pd, output int n);
    @(posedge Clk);
    #1;
    start    = 1'b1;
    reg_addr = a;
    reg_data = d;
    @(posedge Clk);
    #1;
    start    = 1'b0;
    reg_addr = 8'($urandom);
    reg_data = 8'($urandom);
    wait_done(poke, pa, pd, n);
  endtask

  initial begin
    int n, n2, d0;
    logic [7:0] a, d;

    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk("rst_ready", ready, 1);
    chk("rst_sioc", sioc, 1);
    chk("rst_oe", siod_oe, 0);
    chk("rst_done", done, 0);
    chk("rst_nack", nack, 0);
    repeat (1000) @(posedge Clk);
    d0 = ndone;

    do_write(8'h12, 8'h80, -10, 8'h00, 8'h00, n);
    chk("single_latency", n, 464);
    chk("single_dev", {24'd0, dec[26:19]}, 8'h42);
    chk("single_addr", {24'd0, dec[17:10]}, 8'h12);
    chk("single_data", {24'd0, dec[8:1]}, 8'h80);

    do_write(8'h12, 8'h80, 250, 8'h11, 8'h01, n);
    @(posedge Clk);
    chk("busy_latency", n, 464);
    chk("busy_addr", {24'd0, dec[17:10]}, 8'h12);
    chk("busy_data", {24'd0, dec[8:1]}, 8'h80);
    chk("busy_done_count", ndone - d0, 2);

    d0 = ndone;
    @(posedge Clk);
    #1;
    start    = 1'b1;
    reg_addr = 8'h40;
    reg_data = 8'hD0;
    @(posedge Clk);
    #1;
    wait_done(-10, 8'h00, 8'h00, n);
    wait_done(-10, 8'h00, 8'h00, n2);
    start = 1'b0;
    @(posedge Clk);
    chk("b2b_first", n, 464);
    chk("b2b_total", n + n2, 929);
    chk("b2b_done_count", ndone - d0, 2);
    chk("b2b_data", {24'd0, dec[8:1]}, 8'hD0);

    d0 = ndone;
    @(posedge Clk);
    #1;
    start    = 1'b1;
    reg_addr = 8'h12;
    reg_data = 8'h80;
    @(posedge Clk);
    #1 start = 1'b0;
    repeat (240) @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk("rmid_ready", ready, 1);
    chk("rmid_sioc", sioc, 1);
    chk("rmid_oe", siod_oe, 0);
    repeat (600) @(posedge Clk);
    chk("rmid_no_done", ndone - d0, 0);
    do_write(8'h3A, 8'h04, -10, 8'h00, 8'h00, n);
    chk("rmid_latency", n, 464);
    chk("rmid_addr", {24'd0, dec[17:10]}, 8'h3A);
    chk("rmid_data", {24'd0, dec[8:1]}, 8'h04);

    for (int i = 0; i < 12; i++) begin
      a = 8'($urandom);
      d = 8'($urandom);
      repeat ($urandom_range(0, 15)) @(posedge Clk);
      if ($urandom_range(0, 1) == 1)
        do_write(a, d, int'($urandom_range(1, 460)),
                 8'($urandom), 8'($urandom), n);
      else
        do_write(a, d, -10, 8'h00, 8'h00, n);
      chk("rand_latency", n, 464);
    end

    repeat (20) @(posedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
